// File: rtl/spi_target_rx_if.sv
// rtl/spi_target_rx_if.sv - frame result bus between the SPI target front-end and register decode
//
// Purpose: carries one decoded SPI write frame (address/data pair) plus its
//          completion and error strobes.
// Signals:
//   spi_address_o  address field of the last valid frame
//   spi_data_o     data field of the last valid frame
//   is_ready       one-cycle strobe, address/data updated this cycle
//   frame_err_o    one-cycle strobe, short frame or overrun at cs_n rise
// Modports: master = spi_target_rx (drives), slave = register decode (consumes).

interface spi_target_rx_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 12
);
   logic [ADDR_W-1:0] spi_address_o;
   logic [DATA_W-1:0] spi_data_o;
   logic              is_ready;
   logic              frame_err_o;

   modport master (
      output spi_address_o,
      output spi_data_o,
      output is_ready,
      output frame_err_o
   );

   modport slave (
      input spi_address_o,
      input spi_data_o,
      input is_ready,
      input frame_err_o
   );
endinterface

// File: rtl/spi_target_rx.sv
// rtl/spi_target_rx.sv - SPI mode-0 target: pin synchronisers, 16-bit write deserialiser, status readback
//
// Purpose: synchronises sclk/cs_n/mosi into clk, deserialises ADDR_W+DATA_W bit
//          write frames MSB first, and shifts status_i out on MISO during the
//          same frame.
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   sclk_i, cs_n_i, mosi_i  asynchronous SPI pins
//   status_i              readback word, captured at cs_n fall
//   miso_o, miso_oe_o     SPI data out and its output enable
//   bus (master)          decoded frame: spi_address_o, spi_data_o, is_ready, frame_err_o

module spi_target_rx #(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 12,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         sclk_i,
   input  logic         cs_n_i,
   input  logic         mosi_i,
   input  logic [15:0]  status_i,
   output logic         miso_o,
   output logic         miso_oe_o,
   spi_target_rx_if.master bus
);
   localparam int FRAME_W = ADDR_W + DATA_W;
   localparam int ARM_W   = $clog2(SYNC_STAGES + 1);
   localparam logic [4:0] LAST_BIT = 5'(FRAME_W - 1);
   localparam logic [ARM_W-1:0] ARM_FLUSH = ARM_W'(SYNC_STAGES);

   localparam logic [1:0] ST_ARM   = 2'd0;
   localparam logic [1:0] ST_IDLE  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   // ---------------- synchronisers and edge detect ----------------
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic                   sclk_prev;
   logic                   cs_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         cs_sync   <= '1;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
         sclk_prev <= sclk_sync[SYNC_STAGES-1];
         cs_prev   <= cs_sync[SYNC_STAGES-1];
      end
   end

   logic sclk_s, mosi_s, cs_n_s;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign cs_n_s    = cs_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev;
   assign sclk_fall = ~sclk_s & sclk_prev;
   assign cs_rise   = cs_n_s & ~cs_prev;
   assign cs_fall   = ~cs_n_s & cs_prev;

   // ---------------- frame FSM ----------------
   logic [1:0]         state;
   logic [ARM_W-1:0]   arm_cnt;
   logic [4:0]         bit_cnt;
   // Only FRAME_W-1 bits are stored: the final bit is taken straight from
   // mosi_s on the last rise, so the full word never needs to be registered.
   logic [FRAME_W-2:0] shift_in;
   logic [FRAME_W-1:0] shift_next;
   logic [15:0]        tx_shift;
   logic               overrun;

   assign shift_next = {shift_in, mosi_s};
   // tx_shift is zero whenever the frame is inactive, so its MSB is MISO directly.
   assign miso_o     = tx_shift[15];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= ST_ARM;
         arm_cnt           <= '0;
         bit_cnt           <= '0;
         shift_in          <= '0;
         tx_shift          <= '0;
         overrun           <= 1'b0;
         miso_oe_o         <= 1'b0;
         bus.spi_address_o <= '0;
         bus.spi_data_o    <= '0;
         bus.is_ready      <= 1'b0;
         bus.frame_err_o   <= 1'b0;
      end else begin
         bus.is_ready    <= 1'b0;
         bus.frame_err_o <= 1'b0;
         case (state)
            ST_ARM: begin
               // The cs_n synchroniser resets high, so its output means nothing
               // until the real pin has propagated through every stage.
               if (arm_cnt != ARM_FLUSH) begin
                  arm_cnt <= arm_cnt + 1'b1;
               end else if (cs_n_s) begin
                  state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (cs_fall) begin
                  bit_cnt   <= '0;
                  shift_in  <= '0;
                  tx_shift  <= status_i;
                  miso_oe_o <= 1'b1;
                  state     <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // cs_n rise wins over a coincident sclk edge.
               if (cs_rise) begin
                  bus.frame_err_o <= 1'b1;
                  tx_shift        <= '0;
                  miso_oe_o       <= 1'b0;
                  state           <= ST_IDLE;
               end else if (sclk_rise) begin
                  shift_in <= shift_next[FRAME_W-2:0];
                  bit_cnt  <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT) begin
                     bus.spi_address_o <= shift_next[FRAME_W-1:DATA_W];
                     bus.spi_data_o    <= shift_next[DATA_W-1:0];
                     bus.is_ready      <= 1'b1;
                     state             <= ST_HOLD;
                  end
               end else if (sclk_fall) begin
                  tx_shift <= {tx_shift[14:0], 1'b0};
               end
            end
            default: begin // ST_HOLD
               if (cs_rise) begin
                  bus.frame_err_o <= overrun;
                  overrun         <= 1'b0;
                  tx_shift        <= '0;
                  miso_oe_o       <= 1'b0;
                  state           <= ST_IDLE;
               end else if (sclk_rise) begin
                  overrun <= 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spi_target_rx.sv
// tb/tb_spi_target_rx.sv - directed self-checking bench for spi_target_rx

module tb_spi_target_rx;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        sclk;
   logic        cs_n;
   logic        mosi;
   logic [15:0] status;
   logic        miso;
   logic        miso_oe;

   spi_target_rx_if #(.ADDR_W(4), .DATA_W(12)) bus ();

   spi_target_rx #(.ADDR_W(4), .DATA_W(12), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sclk_i    (sclk),
      .cs_n_i    (cs_n),
      .mosi_i    (mosi),
      .status_i  (status),
      .miso_o    (miso),
      .miso_oe_o (miso_oe),
      .bus       (bus.master)
   );

   always #5 clk = ~clk;

   int      checks = 0;
   int      failures = 0;
   int      rdy_cnt = 0;
   int      err_cnt = 0;
   time     rdy_time = 0;
   time     t_rise16 = 0;
   logic [31:0] miso_word;
   logic        oe_all;
   logic [3:0]  rdy_addr[$];
   logic [11:0] rdy_data[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.is_ready === 1'b1) begin
         rdy_cnt++;
         rdy_time = $time;
         rdy_addr.push_back(bus.spi_address_o);
         rdy_data.push_back(bus.spi_data_o);
      end
      if (bus.frame_err_o === 1'b1) err_cnt++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Clocks nbits of word out MSB first, h clk per SCLK phase; MISO sampled
   // just before each rise. status is cleared after bit index clr_at.
   task automatic send_bits(input logic [31:0] word, input int nbits, input int h, input int clr_at);
      for (int i = 0; i < nbits; i++) begin
         mosi = word[nbits-1-i];
         wait_clk(h);
         miso_word = {miso_word[30:0], miso};
         oe_all    = oe_all & miso_oe;
         if (i == 15) t_rise16 = $time;
         sclk = 1'b1;
         wait_clk(h);
         sclk = 1'b0;
         if (i == clr_at) status = 16'h0000;
      end
   endtask

   task automatic spi_frame(input logic [31:0] word, input int nbits, input int h, input int gap, input int clr_at);
      cs_n = 1'b0;
      send_bits(word, nbits, h, clr_at);
      wait_clk(h);
      cs_n = 1'b1;
      wait_clk(gap);
   endtask

   int r0, e0;

   initial begin
      rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; status = 16'h0000;
      miso_word = '0; oe_all = 1'b1;
      wait_clk(3);
      check_eq("rst_addr", 32'(bus.spi_address_o), 32'h0);
      check_eq("rst_data", 32'(bus.spi_data_o), 32'h0);
      check_eq("rst_ready", 32'(bus.is_ready), 32'h0);
      check_eq("rst_err", 32'(bus.frame_err_o), 32'h0);
      check_eq("rst_miso", 32'(miso), 32'h0);
      check_eq("rst_oe", 32'(miso_oe), 32'h0);
      rst_n = 1'b1;
      wait_clk(6);

      // single frame at SCLK = clk/8, with latency check
      r0 = rdy_cnt; e0 = err_cnt;
      spi_frame(32'hC010, 16, 4, 8, -1);
      check_eq("t1_ready_cnt", 32'(rdy_cnt - r0), 32'd1);
      check_eq("t1_addr", 32'(bus.spi_address_o), 32'hC);
      check_eq("t1_data", 32'(bus.spi_data_o), 32'h010);
      check_eq("t1_latency", 32'(rdy_time - t_rise16), 32'd30);
      check_eq("t1_err_cnt", 32'(err_cnt - e0), 32'd0);

      // valid frame then aborted 9-bit frame
      r0 = rdy_cnt; e0 = err_cnt;
      spi_frame(32'h1001, 16, 2, 8, -1);
      spi_frame(32'h1FF, 9, 2, 8, -1);
      check_eq("t2_ready_cnt", 32'(rdy_cnt - r0), 32'd1);
      check_eq("t2_err_cnt", 32'(err_cnt - e0), 32'd1);
      check_eq("t2_addr", 32'(bus.spi_address_o), 32'h1);
      check_eq("t2_data", 32'(bus.spi_data_o), 32'h001);

      // 17 bits: 0xF3FF plus one extra bit -> overrun
      r0 = rdy_cnt; e0 = err_cnt;
      spi_frame({15'd0, 16'hF3FF, 1'b1}, 17, 2, 8, -1);
      check_eq("t3_ready_cnt", 32'(rdy_cnt - r0), 32'd1);
      check_eq("t3_err_cnt", 32'(err_cnt - e0), 32'd1);
      check_eq("t3_addr", 32'(bus.spi_address_o), 32'hF);
      check_eq("t3_data", 32'(bus.spi_data_o), 32'h3FF);

      // MISO readback, status changed mid-frame
      r0 = rdy_cnt;
      status = 16'hA5C3; miso_word = '0; oe_all = 1'b1;
      spi_frame(32'h1234, 16, 4, 8, 5);
      check_eq("t4_miso_word", 32'(miso_word[15:0]), 32'hA5C3);
      check_eq("t4_oe_in_frame", 32'(oe_all), 32'h1);
      check_eq("t4_oe_after", 32'(miso_oe), 32'h0);
      check_eq("t4_miso_after", 32'(miso), 32'h0);
      check_eq("t4_ready_cnt", 32'(rdy_cnt - r0), 32'd1);
      check_eq("t4_data", 32'(bus.spi_data_o), 32'h234);

      // reset mid-frame with cs_n held low and SCLK continuing
      r0 = rdy_cnt; e0 = err_cnt;
      cs_n = 1'b0;
      send_bits(32'h15, 5, 2, -1);
      rst_n = 1'b0;
      wait_clk(2);
      check_eq("t5_rst_addr", 32'(bus.spi_address_o), 32'h0);
      check_eq("t5_rst_data", 32'(bus.spi_data_o), 32'h0);
      check_eq("t5_rst_oe", 32'(miso_oe), 32'h0);
      check_eq("t5_rst_miso", 32'(miso), 32'h0);
      rst_n = 1'b1;
      send_bits(32'hFFFF, 16, 2, -1);
      wait_clk(2);
      cs_n = 1'b1;
      wait_clk(6);
      check_eq("t5_no_ready", 32'(rdy_cnt - r0), 32'd0);
      check_eq("t5_no_err", 32'(err_cnt - e0), 32'd0);
      check_eq("t5_addr_held0", 32'(bus.spi_address_o), 32'h0);
      spi_frame(32'hE032, 16, 2, 8, -1);
      check_eq("t5_ready_cnt", 32'(rdy_cnt - r0), 32'd1);
      check_eq("t5_addr", 32'(bus.spi_address_o), 32'hE);
      check_eq("t5_data", 32'(bus.spi_data_o), 32'h032);

      // back-to-back frames, cs_n high for 2 clk
      r0 = rdy_cnt; e0 = err_cnt;
      rdy_addr.delete(); rdy_data.delete();
      spi_frame(32'hD001, 16, 2, 2, -1);
      spi_frame(32'hC040, 16, 2, 8, -1);
      check_eq("t6_ready_cnt", 32'(rdy_cnt - r0), 32'd2);
      check_eq("t6_err_cnt", 32'(err_cnt - e0), 32'd0);
      if (rdy_addr.size() == 2) begin
         check_eq("t6_addr0", 32'(rdy_addr[0]), 32'hD);
         check_eq("t6_data0", 32'(rdy_data[0]), 32'h001);
         check_eq("t6_addr1", 32'(rdy_addr[1]), 32'hC);
         check_eq("t6_data1", 32'(rdy_data[1]), 32'h040);
      end else begin
         check_eq("t6_pairs", 32'(rdy_addr.size()), 32'd2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/spi_target_rx.md
Name: spi_target_rx

Overview:
SPI target front-end that sits directly upstream of the register-decode controller. Owns the off-chip SPI pins: sclk, cs_n and mosi. Synchronises those pins into the system clock domain and deserialises 16-bit write frames into an address/data pair. Presents each frame with a single-cycle is_ready strobe, and shifts a 16-bit status word out on MISO during the same frame.

Parameters:
ADDR_W, 4, address field width (frame bits [15:12])
DATA_W, 12, data field width (frame bits [11:0]); frame length = ADDR_W+DATA_W = 16
SYNC_STAGES, 2, flip-flop stages per input synchroniser (minimum 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sclk_i  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk
cs_n_i  in  1  SPI chip select, active low, asynchronous
mosi_i  in  1  SPI data in, MSB first, asynchronous
status_i  in  16  readback word, captured at frame start
miso_o  out  1  SPI data out
miso_oe_o  out  1  MISO output enable (high while the frame is active)
spi_address_o  out  ADDR_W  address of the last valid frame
spi_data_o  out  DATA_W  data of the last valid frame
is_ready  out  1  one-cycle strobe: spi_address_o/spi_data_o were updated this cycle
frame_err_o  out  1  one-cycle strobe: short frame or overrun detected at cs_n rise

Behaviour:
- Reset values:
  - All outputs 0.
  - sclk and mosi synchroniser flops reset to 0; cs_n synchroniser flops reset to 1.
  - State = ARM.
- Edge detect: a registered copy of each synchronised signal; rise = s & ~prev, fall = ~s & prev.
- mosi uses the same synchroniser depth as sclk, so mosi_s is aligned with sclk_s.
- Timing requirements on the SPI master:
  - SCLK high and low phases each ≥ 2 clk periods for writes.
  - Each phase ≥ 4 clk periods when MISO readback is used.
  - cs_n high time ≥ 2 clk periods between frames.
- States:
  - ARM: wait for cs_n_s==1, then go to IDLE. This prevents a false frame when reset releases while cs_n is held low.
  - IDLE: on cs_n fall:
    - bit_cnt=0, shift_in=0.
    - tx_shift=status_i.
    - miso_o=status_i[15], miso_oe_o=1.
    - go to SHIFT.
  - SHIFT:
    - On sclk rise: shift_in={shift_in[14:0],mosi_s}, bit_cnt++.
    - On sclk fall: tx_shift<<=1, miso_o=next bit.
    - On the 16th rise, in the same clk edge:
      - spi_address_o={shift_in[14:0],mosi_s}[15:12].
      - spi_data_o={shift_in[14:0],mosi_s}[11:0].
      - is_ready<=1.
      - go to HOLD.
    - On cs_n rise with bit_cnt<16: frame_err_o pulse, outputs unchanged, go to IDLE.
  - HOLD:
    - Further sclk edges are ignored for data; any extra rise sets the overrun flag.
    - On cs_n rise: frame_err_o pulse if overrun is set, clear overrun, go to IDLE.
- Frame-end latency: is_ready is high in the cycle after clk edge k+2, where k is the first clk edge that samples the 16th physical SCLK high.
- is_ready is high for exactly one clk cycle per valid frame.
- Hold behaviour: spi_address_o/spi_data_o hold their values until the next valid frame. They never change on aborted frames.
- Simultaneous cs_n rise and sclk rise in the same cycle: cs_n takes priority; the sclk edge is ignored.
- MISO:
  - miso_o=0 and miso_oe_o=0 outside SHIFT/HOLD.
  - In HOLD, miso_o holds the last bit.
  - status_i changes after capture do not affect the current frame.
- bit_cnt is 5 bits and never wraps; it saturates at 16 in HOLD.
- Reset mid-frame: immediate return to reset values and state ARM. A new frame is accepted only after cs_n has been observed high.

Test Plan:
- Write frame 0xC010 (addr 12, data 0x010) at SCLK = clk/8 -> exactly one is_ready pulse; spi_address_o=4'hC, spi_data_o=12'h010, 2 clk edges after the sampled 16th rise; frame_err_o stays 0.
- Valid frame 0x1001, then a frame aborted after 9 bits -> no is_ready for the second frame; one frame_err_o pulse at cs_n rise; outputs still 4'h1/12'h001.
- 17 SCLK pulses carrying 0xF3FF plus one extra bit -> is_ready once with addr 4'hF, data 12'h3FF; frame_err_o pulse at cs_n rise.
- status_i=0xA5C3 at cs_n fall, then changed to 0x0000 mid-frame -> MISO sampled on SCLK rises reads 1010_0101_1100_0011; miso_oe_o high only while cs_n low.
- rst_n pulsed low mid-frame with cs_n held low, SCLK continuing -> all outputs 0, no is_ready until cs_n goes high then low; the next full frame 0xE032 yields addr 4'hE, data 12'h032.
- Back-to-back frames 0xD001, 0xC040 with cs_n high for 2 clk -> two is_ready pulses with the correct pairs; no frame_err_o.
